// File: rtl/xfft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xfft_pkg
// Brief    : Shared sizes, FSM encodings and config-word packing for the
//            XFFT bank sequencer.
// Revision : 1.0
// ============================================================================
package xfft_pkg;

  localparam int N         = 16;
  localparam int NFFT_LOG2 = 15;
  localparam int CFG_W     = 8;
  localparam int FRM_W     = 16;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_CFG    = 2'd1;
  localparam state_t S_STREAM = 2'd2;
  localparam state_t S_DRAIN  = 2'd3;

  // Bit 0 selects direction, the upper bits carry the scale schedule.
  function automatic logic [CFG_W-1:0] pack_cfg(input logic [CFG_W-2:0] scale,
                                                input logic             fwd_inv);
    return {scale, fwd_inv};
  endfunction

endpackage
`default_nettype wire

// File: rtl/xfft_cfg_issuer.sv
`default_nettype none
// ============================================================================
// Module   : xfft_cfg_issuer
// Brief    : Per-core config valid mask; each core gets exactly one beat.
// Revision : 1.0
// ============================================================================
module xfft_cfg_issuer #(
  parameter int N = xfft_pkg::N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [N-1:0] ready_i,
  output logic [N-1:0] valid_o,
  output logic         all_done_o
);

  logic [N-1:0] valid_q;
  logic [N-1:0] valid_d;
  logic [N-1:0] remain;

  always_comb begin
    remain  = valid_q & ~ready_i;
    valid_d = load_i ? {N{1'b1}} : remain;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign valid_o    = valid_q;
  // Looks at the post-handshake mask so the FSM can leave CFG on the last ack.
  assign all_done_o = (remain == '0);

endmodule
`default_nettype wire

// File: rtl/xfft_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : xfft_bank_ctrl
// Brief    : Start/config/stream/drain sequencer for the parallel XFFT bank.
// Revision : 1.0
// ============================================================================
module xfft_bank_ctrl #(
  parameter int N         = xfft_pkg::N,
  parameter int NFFT_LOG2 = xfft_pkg::NFFT_LOG2,
  parameter int CFG_W     = xfft_pkg::CFG_W,
  parameter int FRM_W     = xfft_pkg::FRM_W
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             fwd_inv_i,
  input  logic [CFG_W-2:0] scale_i,
  input  logic [FRM_W-1:0] nframes_i,
  output logic [CFG_W-1:0] m_axis_cfg_tdata,
  output logic [N-1:0]     m_axis_cfg_tvalid,
  input  logic [N-1:0]     m_axis_cfg_tready,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic             fft_tvalid,
  output logic             fft_tlast,
  input  logic             fft_out_tvalid,
  input  logic             fft_out_tlast,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [FRM_W-1:0] frames_in_o,
  output logic [FRM_W-1:0] frames_out_o
);

  import xfft_pkg::*;

  state_t               state_q,     state_d;
  logic [CFG_W-1:0]     cfg_q,       cfg_d;
  logic [FRM_W-1:0]     nframes_q,   nframes_d;
  logic [FRM_W-1:0]     fin_q,       fin_d;
  logic [FRM_W-1:0]     fout_q,      fout_d;
  logic [NFFT_LOG2-1:0] cnt_q,       cnt_d;
  logic                 stop_pend_q, stop_pend_d;
  logic                 err_q,       err_d;

  logic cfg_load;
  logic cfg_all_done;
  logic beat;
  logic last_beat;
  logic out_last;
  logic frame_limit;

  xfft_cfg_issuer #(
    .N (N)
  ) u_cfg_issuer (
    .clk        (aclk),
    .rst        (areset),
    .load_i     (cfg_load),
    .ready_i    (m_axis_cfg_tready),
    .valid_o    (m_axis_cfg_tvalid),
    .all_done_o (cfg_all_done)
  );

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    nframes_d   = nframes_q;
    fin_d       = fin_q;
    fout_d      = fout_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    err_d       = err_q;
    cfg_load    = 1'b0;

    beat        = (state_q == S_STREAM) && s_axis_tvalid;
    last_beat   = beat && (cnt_q == '1);
    out_last    = fft_out_tvalid && fft_out_tlast;
    frame_limit = (nframes_q != '0) && ((fin_q + FRM_W'(1)) == nframes_q);

    // Output frames are tracked in every state so a stray tlast is always caught.
    if (out_last) begin
      if (fout_q < fin_q) begin
        fout_d = fout_q + FRM_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end

    if (beat) begin
      cnt_d = cnt_q + NFFT_LOG2'(1);
    end
    if (last_beat && (fin_q != '1)) begin
      fin_d = fin_q + FRM_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_CFG;
          cfg_load    = 1'b1;
          cfg_d       = pack_cfg(scale_i, fwd_inv_i);
          nframes_d   = nframes_i;
          cnt_d       = '0;
          fin_d       = '0;
          fout_d      = '0;
          err_d       = 1'b0;
          stop_pend_d = 1'b0;
        end
      end
      S_CFG: begin
        if (stop_i) begin
          stop_pend_d = 1'b1;
        end
        if (cfg_all_done) begin
          state_d = (stop_i || stop_pend_q) ? S_DRAIN : S_STREAM;
        end
      end
      S_STREAM: begin
        if (last_beat) begin
          if (frame_limit || stop_pend_q || stop_i) begin
            state_d = S_DRAIN;
          end
        end else if (stop_i) begin
          // A stop between frames leaves at once; mid-frame it waits for tlast.
          if ((cnt_q == '0) && !beat) begin
            state_d = S_DRAIN;
          end else begin
            stop_pend_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (fout_q == fin_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      cfg_q       <= '0;
      nframes_q   <= '0;
      fin_q       <= '0;
      fout_q      <= '0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      nframes_q   <= nframes_d;
      fin_q       <= fin_d;
      fout_q      <= fout_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      err_q       <= err_d;
    end
  end

  assign m_axis_cfg_tdata = cfg_q;
  assign s_axis_tready    = (state_q == S_STREAM);
  assign fft_tvalid       = beat;
  assign fft_tlast        = last_beat;
  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = (state_q == S_DRAIN) && (fout_q == fin_q);
  assign err_o            = err_q;
  assign frames_in_o      = fin_q;
  assign frames_out_o     = fout_q;

endmodule
`default_nettype wire

// File: doc/xfft_bank_ctrl.md
Name: xfft_bank_ctrl

Overview:
- Sequencer for the 16-lane XFFT bank (16 parallel 32768-point cores sharing one config word and one input valid).
- On a start command it:
  - programs all cores with direction and scaling;
  - opens the input stream for a programmed number of frames (or continuously);
  - generates per-frame tlast;
  - tracks completed output frames until the bank has drained.
- Sits between the register/control interface and the XFFT bank wrapper, in the aclk domain.

Parameters:
- N, 16, number of parallel XFFT cores.
- NFFT_LOG2, 15, log2 of points per core (frame = 2^NFFT_LOG2 beats).
- CFG_W, 8, config word width; bit 0 = fwd_inv, bits CFG_W-1:1 = scale schedule.
- FRM_W, 16, width of frame counters.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous active-high reset.
- start_i  in  1  single-cycle start pulse.
- stop_i  in  1  single-cycle stop request (finish current frame, then drain).
- fwd_inv_i  in  1  1 = forward FFT, 0 = inverse FFT.
- scale_i  in  CFG_W-1  scaling schedule.
- nframes_i  in  FRM_W  frames to process; 0 = continuous until stop_i.
- m_axis_cfg_tdata  out  CFG_W  config word, shared by all cores.
- m_axis_cfg_tvalid  out  N  per-core config valid.
- m_axis_cfg_tready  in  N  per-core config ready.
- s_axis_tvalid  in  1  upstream data valid.
- s_axis_tready  out  1  upstream ready.
- fft_tvalid  out  1  data valid to all cores.
- fft_tlast  out  1  frame-end marker to all cores.
- fft_out_tvalid  in  1  core 0 output valid.
- fft_out_tlast  in  1  core 0 output tlast.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when drain completes.
- err_o  out  1  sticky: output tlast seen with no frame outstanding.
- frames_in_o  out  FRM_W  frames sent since start.
- frames_out_o  out  FRM_W  frames completed since start.

Behaviour:
- Reset (areset sampled high on an aclk edge):
  - state goes to IDLE;
  - all outputs 0;
  - sample counter and both frame counters 0;
  - stop-pending flag and err_o cleared.
  - Reset mid-operation aborts immediately; the cores are not reset by this block.
- Start handling:
  - start_i is honoured only in IDLE and is ignored while busy.
  - On start, latch {scale_i, fwd_inv_i} into m_axis_cfg_tdata, latch nframes_i, clear the counters and err_o.
- IDLE:
  - s_axis_tready = 0, fft_tvalid = 0, all cfg valids 0.
  - start_i -> CFG; m_axis_cfg_tvalid = all ones on the next cycle (latency 1).
- CFG:
  - Each bit i of m_axis_cfg_tvalid clears on the cycle after valid[i] & ready[i].
  - Cores acknowledge independently and in any order; each core receives exactly one config beat.
  - When the valid vector is zero (or becomes zero this cycle) -> STREAM.
  - stop_i in CFG sets stop-pending; on leaving CFG go straight to DRAIN.
- STREAM:
  - s_axis_tready = 1; fft_tvalid = s_axis_tvalid (combinational, zero latency).
  - Sample counter (NFFT_LOG2 bits) increments on each valid beat and wraps to 0 after 2^NFFT_LOG2-1.
  - fft_tlast = s_axis_tvalid & (count == all ones).
  - On a tlast beat, frames_in increments.
  - If nframes != 0 and frames_in+1 == nframes, or stop-pending is set, then -> DRAIN after that beat.
  - stop_i with count == 0 and no beat this cycle -> DRAIN immediately. Otherwise set stop-pending; the current frame always completes.
  - stop_i coincident with a tlast beat -> DRAIN after that beat.
- DRAIN:
  - s_axis_tready = 0, fft_tvalid = 0.
  - When frames_out == frames_in: done_o pulses, then -> IDLE. This includes the case of zero frames sent.
- Output tracking (all states except reset):
  - fft_out_tvalid & fft_out_tlast increments frames_out if frames_out < frames_in.
  - Otherwise err_o is set and frames_out holds.
  - Simultaneous input tlast and output tlast are both counted in the same cycle.
- Counter overflow:
  - Frame counters saturate at all ones in continuous mode.
  - Once saturated, drain completes when both counters are saturated.

Decomposition:
- Shared package xfft_pkg:
  - N, NFFT_LOG2, CFG_W, FRM_W;
  - state enum {IDLE, CFG, STREAM, DRAIN};
  - config-word pack function {scale, fwd_inv}.
- One sub-module, xfft_cfg_issuer: the per-core valid mask, with load and all-done outputs.
- Frame/sample counting stays in the top module.

Test Plan:
- Reset, then start with fwd_inv=1, scale=7'h2A, nframes=2; cores ready in order 15..0 over 16 cycles -> cfg_tdata=8'h55; each valid bit drops once; STREAM entered after the last ack.
- STREAM with continuous s_axis_tvalid for 2 frames (with NFFT_LOG2 overridden to 4) -> fft_tlast on beats 15 and 31; s_axis_tready falls after beat 31; frames_in_o=2.
- Then inject 2 output tlasts -> done_o pulses once, 1 cycle after the second tlast; busy_o=0; frames_out_o=2.
- nframes=0, stop_i at beat 5 of frame 0 -> tlast at beat 15; DRAIN; done_o after one output tlast.
- An extra output tlast after done -> err_o=1 and stays set until the next start.
- areset asserted mid-STREAM -> next cycle all outputs 0, state IDLE; start_i while busy -> no effect on counters or cfg.
